// File: rtl/gb_int_ctrl_if.sv
// CPU memory-bus port of the interrupt controller: address/data strobes in,
// read data and read-select back to the CPU-side read mux.
interface gb_int_ctrl_if;
    logic [15:0] address;
    logic [7:0]  wdata;
    logic        store;
    logic        load;
    logic [7:0]  rdata;
    logic        sel;

    modport master (
        output address, wdata, store, load,
        input  rdata, sel
    );

    modport slave (
        input  address, wdata, store, load,
        output rdata, sel
    );
endinterface

// File: rtl/gb_int_ctrl.sv
// Game Boy interrupt controller: IF/IE registers, source edge capture,
// fixed-priority request and vector generation for the CPU core.
module gb_int_ctrl #(
    parameter logic [15:0] IF_ADDR  = 16'hFF0F,
    parameter logic [15:0] IE_ADDR  = 16'hFFFF,
    parameter logic [15:0] VEC_BASE = 16'h0040
) (
    input  logic              clock,
    input  logic              resetn,
    gb_int_ctrl_if.slave      bus,
    input  logic [4:0]        src_i,
    output logic              intreq_o,
    output logic [15:0]       intaddress_o,
    input  logic              intack_i
);

    logic [4:0]  if_q, if_d;
    logic [7:0]  ie_q, ie_d;
    logic [4:0]  src_q;
    logic [15:0] vec_q, vec_d;

    logic [4:0]  rise;
    logic [4:0]  pending;
    logic [4:0]  ack_clr;
    logic [2:0]  win_idx;
    logic        win_valid;
    logic        hit_if, hit_ie;

    assign rise    = src_i & ~src_q;
    assign pending = if_q & ie_q[4:0];
    assign hit_if  = (bus.address == IF_ADDR);
    assign hit_ie  = (bus.address == IE_ADDR);

    // Scan downward so the lowest pending bit is left as the winner.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 3'd0;
        for (int n = 4; n >= 0; n--) begin
            if (pending[n]) begin
                win_valid = 1'b1;
                win_idx   = 3'(n);
            end
        end
    end

    always_comb begin
        ack_clr = 5'b00000;
        if (intack_i && win_valid) begin
            ack_clr = 5'b00001 << win_idx;
        end
    end

    // Source edges beat CPU writes, which beat the acknowledge clear.
    always_comb begin
        if_d = rise | ((bus.store && hit_if) ? bus.wdata[4:0] : (if_q & ~ack_clr));
        ie_d = (bus.store && hit_ie) ? bus.wdata : ie_q;
        vec_d = vec_q;
        if (intack_i) begin
            vec_d = win_valid ? (VEC_BASE + {10'b0, win_idx, 3'b000}) : 16'h0000;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            if_q  <= 5'b00000;
            ie_q  <= 8'h00;
            src_q <= 5'b00000;
            vec_q <= 16'h0000;
        end else begin
            if_q  <= if_d;
            ie_q  <= ie_d;
            src_q <= src_i;
            vec_q <= vec_d;
        end
    end

    always_comb begin
        bus.sel   = bus.load && (hit_if || hit_ie);
        bus.rdata = 8'hFF;
        if (bus.load && hit_if) begin
            bus.rdata = {3'b111, if_q};
        end else if (bus.load && hit_ie) begin
            bus.rdata = ie_q;
        end
    end

    assign intreq_o     = |pending;
    assign intaddress_o = vec_q;

endmodule

// File: tb/tb_gb_int_ctrl.sv
// Bench for gb_int_ctrl: directed scenarios plus random traffic, all checked
// against a register-level reference model of the interrupt rules.
module tb_gb_int_ctrl;

    logic        clock;
    logic        resetn;
    logic [4:0]  src;
    logic        intack;
    logic        intreq;
    logic [15:0] intaddress;

    gb_int_ctrl_if bus ();

    gb_int_ctrl dut (
        .clock        (clock),
        .resetn       (resetn),
        .bus          (bus),
        .src_i        (src),
        .intreq_o     (intreq),
        .intaddress_o (intaddress),
        .intack_i     (intack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [4:0]  m_if;
    logic [7:0]  m_ie;
    logic [4:0]  m_prev;
    logic [15:0] m_vec;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_if   = '0;
        m_ie   = '0;
        m_prev = '0;
        m_vec  = '0;
    endtask

    // One bus cycle: drive after falling edge, check outputs mid-cycle,
    // then advance the model on the rising edge.
    task automatic cyc(input logic [15:0] a, input logic [7:0] wd, input logic st,
                       input logic ld, input logic [4:0] s, input logic ack,
                       output logic [7:0] rd, output logic rq, output logic [15:0] va);
        logic        e_sel;
        logic [7:0]  e_rd;
        logic [4:0]  pend;
        int          win;
        @(negedge clock);
        bus.address = a;
        bus.wdata   = wd;
        bus.store   = st;
        bus.load    = ld;
        src         = s;
        intack      = ack;
        #1;
        e_sel = ld && (a == 16'hFF0F || a == 16'hFFFF);
        e_rd  = !e_sel ? 8'hFF : (a == 16'hFF0F ? {3'b111, m_if} : m_ie);
        check("sel", bus.sel, e_sel);
        check("rdata", bus.rdata, e_rd);
        check("intreq", intreq, ((m_if & m_ie[4:0]) != 0));
        check("intaddress", intaddress, m_vec);
        rd = bus.rdata;
        rq = intreq;
        va = intaddress;
        @(posedge clock);
        pend = m_if & m_ie[4:0];
        win  = -1;
        for (int n = 0; n < 5; n++) if (pend[n] && win < 0) win = n;
        if (ack) m_vec = (win >= 0) ? 16'(16'h0040 + 8 * win) : 16'h0000;
        for (int n = 0; n < 5; n++) begin
            if (s[n] && !m_prev[n])            m_if[n] = 1'b1;
            else if (st && a == 16'hFF0F)      m_if[n] = wd[n];
            else if (ack && win == n)          m_if[n] = 1'b0;
        end
        if (st && a == 16'hFFFF) m_ie = wd;
        m_prev = s;
    endtask

    logic [7:0]  rd;
    logic        rq;
    logic [15:0] va;

    initial begin
        resetn = 1'b0;
        bus.address = '0; bus.wdata = '0; bus.store = 0; bus.load = 0;
        src = '0; intack = 0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;

        // Reset state
        cyc(16'hFF0F, 8'h00, 0, 1, 5'h00, 0, rd, rq, va);
        check("rst_if", rd, 8'hE0); check("rst_req", rq, 0); check("rst_vec", va, 16'h0000);
        cyc(16'hFFFF, 8'h00, 0, 1, 5'h00, 0, rd, rq, va);
        check("rst_ie", rd, 8'h00);
        cyc(16'hFF00, 8'h00, 0, 1, 5'h00, 0, rd, rq, va);
        check("other_rd", rd, 8'hFF);

        // Timer single interrupt
        cyc(16'hFFFF, 8'h04, 1, 0, 5'h00, 0, rd, rq, va);
        cyc(16'h0000, 8'h00, 0, 0, 5'h04, 0, rd, rq, va);
        cyc(16'hFF0F, 8'h00, 0, 1, 5'h00, 0, rd, rq, va);
        check("tmr_if", rd, 8'hE4); check("tmr_req", rq, 1);
        cyc(16'h0000, 8'h00, 0, 0, 5'h00, 1, rd, rq, va);
        cyc(16'hFF0F, 8'h00, 0, 1, 5'h00, 0, rd, rq, va);
        check("tmr_vec", va, 16'h0050); check("tmr_if2", rd, 8'hE0); check("tmr_req2", rq, 0);

        // Two sources, back-to-back acknowledges
        cyc(16'hFFFF, 8'h1F, 1, 0, 5'h00, 0, rd, rq, va);
        cyc(16'h0000, 8'h00, 0, 0, 5'h11, 0, rd, rq, va);
        cyc(16'h0000, 8'h00, 0, 0, 5'h00, 1, rd, rq, va);
        cyc(16'h0000, 8'h00, 0, 0, 5'h00, 1, rd, rq, va);
        check("b2b_vec0", va, 16'h0040);
        cyc(16'hFF0F, 8'h00, 0, 1, 5'h00, 0, rd, rq, va);
        check("b2b_vec1", va, 16'h0060); check("b2b_if", rd, 8'hE0);

        // Level-held source sets IF only once
        for (int i = 0; i < 10; i++) cyc(16'hFF0F, 8'h00, 0, 1, 5'h02, 0, rd, rq, va);
        check("hold_if", rd, 8'hE2);
        cyc(16'hFF0F, 8'h00, 1, 0, 5'h02, 0, rd, rq, va);
        cyc(16'hFF0F, 8'h00, 0, 1, 5'h02, 0, rd, rq, va);
        check("hold_clr", rd, 8'hE0);
        cyc(16'h0000, 8'h00, 0, 0, 5'h00, 0, rd, rq, va);
        cyc(16'h0000, 8'h00, 0, 0, 5'h02, 0, rd, rq, va);
        cyc(16'hFF0F, 8'h00, 0, 1, 5'h00, 0, rd, rq, va);
        check("rerise_if", rd, 8'hE2);
        cyc(16'hFF0F, 8'h00, 1, 0, 5'h00, 0, rd, rq, va);

        // Edge vs write vs ack in the same cycle
        cyc(16'h0000, 8'h00, 0, 0, 5'h08, 0, rd, rq, va);
        cyc(16'h0000, 8'h00, 0, 0, 5'h00, 0, rd, rq, va);
        cyc(16'hFF0F, 8'h00, 1, 0, 5'h08, 1, rd, rq, va);
        cyc(16'hFF0F, 8'h00, 0, 1, 5'h00, 0, rd, rq, va);
        check("race_if", rd, 8'hE8); check("race_vec", va, 16'h0058);
        cyc(16'hFF0F, 8'h00, 1, 0, 5'h00, 0, rd, rq, va);

        // Ack with nothing pending
        cyc(16'hFFFF, 8'h01, 1, 0, 5'h00, 0, rd, rq, va);
        cyc(16'hFF0F, 8'h01, 1, 0, 5'h00, 0, rd, rq, va);
        cyc(16'hFFFF, 8'h00, 1, 0, 5'h00, 0, rd, rq, va);
        cyc(16'h0000, 8'h00, 0, 0, 5'h00, 1, rd, rq, va);
        cyc(16'hFF0F, 8'h00, 0, 1, 5'h00, 0, rd, rq, va);
        check("nopend_vec", va, 16'h0000); check("nopend_if", rd, 8'hE1);

        // Asynchronous reset mid-operation
        cyc(16'hFFFF, 8'h01, 1, 0, 5'h00, 0, rd, rq, va);
        cyc(16'h0000, 8'h00, 0, 0, 5'h00, 1, rd, rq, va);
        cyc(16'h0000, 8'h00, 0, 0, 5'h00, 0, rd, rq, va);
        check("pre_rst_vec", va, 16'h0040);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        check("arst_vec", intaddress, 16'h0000);
        check("arst_req", intreq, 0);
        model_reset();
        @(negedge clock);
        resetn = 1'b1;
        cyc(16'hFF0F, 8'h00, 0, 1, 5'h00, 0, rd, rq, va);
        check("arst_if", rd, 8'hE0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [15:0] a;
            logic [4:0]  s;
            case ($urandom_range(0, 3))
                0, 1:    a = 16'hFF0F;
                2:       a = 16'hFFFF;
                default: a = 16'($urandom);
            endcase
            s = ($urandom_range(0, 2) == 0) ? 5'($urandom) : m_prev;
            cyc(a, 8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                s, ($urandom_range(0, 3) == 0), rd, rq, va);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
